// File: rtl/btn_debounce_multi_if.sv
// Button conditioner bus: raw pins in, debounced level and pulses out.
// The board/control side uses the master modport, the debouncer uses slave.
interface btn_debounce_multi_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic             tick;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_long, tick
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_long, tick
  );
endinterface : btn_debounce_multi_if

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, shared sample tick,
// consecutive-sample stability filter, press/release pulses and an optional
// long-press pulse. Define BTN_LONG_PRESS_EN to build the long-press hold
// counters; without it btn_long is tied to zero.
module btn_debounce_multi #(
  parameter int          N_BTN          = 4,
  parameter logic [19:0] SAMPLE_CNT     = 20'd1000,
  parameter int          STABLE_SAMPLES = 3,
  parameter int          LONG_SAMPLES   = 100,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic                  clock,
  input  logic                  n_reset,
  btn_debounce_multi_if.slave   bus
);

  // Filter counter only needs to hold 0..STABLE_SAMPLES-1.
  localparam int               FW       = $clog2(STABLE_SAMPLES + 1);
  localparam logic [FW-1:0]    FILT_ONE = FW'(1);

  // ---------------------------------------------------------------------------
  // Shared sample tick
  // ---------------------------------------------------------------------------
  logic [19:0] cnt_q, cnt_d;
  logic        tick;

  assign tick = (cnt_q == SAMPLE_CNT);

  // Tick divider: count 0..SAMPLE_CNT and wrap.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and optional polarity inversion
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] s;

  // Two-stage shift of the raw pins into the clock domain.
  always_comb begin
    sync1_d = bus.btn_in;
    sync2_d = sync1_q;
  end

  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Stability filter and press/release pulses
  // ---------------------------------------------------------------------------
  logic [FW-1:0]    filt_q [N_BTN];
  logic [FW-1:0]    filt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q,   rel_d;

  // Per channel on each tick: an agreeing sample clears the count, the
  // STABLE_SAMPLES-th consecutive differing sample flips the level.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      filt_d[i] = filt_q[i];
      if (tick) begin
        if (s[i] == level_q[i]) begin
          filt_d[i] = '0;
        end else if (int'(filt_q[i]) + 1 == STABLE_SAMPLES) begin
          filt_d[i]  = '0;
          level_d[i] = ~level_q[i];
          press_d[i] = ~level_q[i];
          rel_d[i]   =  level_q[i];
        end else begin
          filt_d[i] = filt_q[i] + FILT_ONE;
        end
      end
    end
  end

  // State registers for divider, synchroniser, filter and pulses.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values; the filter counter array is reset because a stale partial
  // count after reset would shorten the first qualification.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < N_BTN; i++) filt_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < N_BTN; i++) filt_q[i] <= filt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------------------
`ifdef BTN_LONG_PRESS_EN
  localparam logic [15:0] LONG_MAX = 16'(LONG_SAMPLES);
  localparam logic [15:0] LONG_PRE = 16'(LONG_SAMPLES - 1);

  logic [15:0]      hold_q [N_BTN];
  logic [15:0]      hold_d [N_BTN];
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] flip;

  assign flip = level_d ^ level_q;

  // Hold counter runs once per tick while pressed, saturates, and pulses
  // btn_long only on the increment that reaches LONG_SAMPLES.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i] || flip[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] < LONG_MAX) begin
        hold_d[i] = hold_q[i] + 16'd1;
        long_d[i] = (hold_q[i] == LONG_PRE);
      end
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      long_q <= '0;
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = '0;
`endif

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;
  assign bus.tick        = tick;

endmodule : btn_debounce_multi

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi (N_BTN=4, SAMPLE_CNT=1000,
// STABLE_SAMPLES=3, LONG_SAMPLES=5). Expected pulse events go into a queue as
// each step is driven; a negedge monitor pops and compares every pulse.
module tb_btn_debounce_multi;

`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clock;
  logic n_reset;

  btn_debounce_multi_if #(.N_BTN(4)) bus ();

  btn_debounce_multi #(
    .N_BTN          (4),
    .SAMPLE_CNT     (20'd1000),
    .STABLE_SAMPLES (3),
    .LONG_SAMPLES   (5),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } ev_t;

  ev_t ev_q[$];

  typedef struct {
    string      name;
    logic [3:0] btn;
    int         ticks;
    logic [3:0] exp_level;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
    logic [3:0] exp_lng;
  } vec_t;

  vec_t vecs[$];

  task automatic push_ev(input string name, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] l);
    ev_t e;
    logic [3:0] lm;
    lm = LONG_EN ? l : 4'b0000;
    if ((p | r | lm) != 4'b0000) begin
      e.name  = name;
      e.press = p;
      e.rel   = r;
      e.lng   = lm;
      ev_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: every cycle with any pulse must match the next entry.
  always @(negedge clock) begin
    if (n_reset && (bus.btn_press | bus.btn_release | bus.btn_long) != 4'b0000) begin
      if (ev_q.size() == 0) begin
        check("unexpected_pulse",
              {20'd0, bus.btn_press, bus.btn_release, bus.btn_long}, 32'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check({"pulse_", e.name},
              {20'd0, bus.btn_press, bus.btn_release, bus.btn_long},
              {20'd0, e.press, e.rel, e.lng});
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      do begin
        @(negedge clock);
        guard++;
      end while (!bus.tick && guard < 2000);
      if (!bus.tick) begin
        tests++;
        errors++;
        $display("FAIL tick_timeout: got no tick in %0d clocks expected one", guard);
      end
    end
  endtask

  task automatic add(input string name, input logic [3:0] btn, input int ticks,
                     input logic [3:0] lvl, input logic [3:0] p, input logic [3:0] r,
                     input logic [3:0] l);
    vec_t v;
    v.name = name; v.btn = btn; v.ticks = ticks; v.exp_level = lvl;
    v.exp_press = p; v.exp_rel = r; v.exp_lng = l;
    vecs.push_back(v);
  endtask

  initial begin
    int n;

    // Step table: input held for 'ticks' samples, level and event expected at
    // the end. Long pulses fall 5 ticks after the tick that set the level.
    add("ch0_wait",      4'b0001, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("ch0_press",     4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add("ch1_bounce_hi", 4'b0011, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add("ch1_bounce_lo", 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add("ch1_hi_again",  4'b0011, 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add("ch1_press",     4'b0011, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    add("ch0_rel_wait",  4'b0010, 2, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    add("ch0_release",   4'b0010, 1, 4'b0010, 4'b0000, 4'b0001, 4'b0000);
    add("ch2_wait",      4'b0110, 2, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    add("ch2_press",     4'b0110, 1, 4'b0110, 4'b0100, 4'b0000, 4'b0000);
    add("ch2_hold4",     4'b0110, 4, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    add("ch2_long",      4'b0110, 1, 4'b0110, 4'b0000, 4'b0000, 4'b0100);
    add("ch2_no_repeat", 4'b0110, 3, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    add("rel_ch1_ch2",   4'b0000, 3, 4'b0000, 4'b0000, 4'b0110, 4'b0000);
    add("all_press",     4'b1111, 3, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    add("all_long",      4'b1111, 5, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    add("rel_ch012",     4'b1000, 3, 4'b1000, 4'b0000, 4'b0111, 4'b0000);

    bus.btn_in = 4'b0000;
    n_reset    = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_level", {28'd0, bus.btn_level}, 32'd0);
    check("reset_pulses", {20'd0, bus.btn_press, bus.btn_release, bus.btn_long}, 32'd0);
    check("reset_tick", {31'd0, bus.tick}, 32'd0);
    n_reset = 1'b1;

    foreach (vecs[i]) begin
      bus.btn_in = vecs[i].btn;
      push_ev(vecs[i].name, vecs[i].exp_press, vecs[i].exp_rel, vecs[i].exp_lng);
      wait_ticks(vecs[i].ticks);
      @(negedge clock);
      check({"level_", vecs[i].name}, {28'd0, bus.btn_level}, {28'd0, vecs[i].exp_level});
    end

    // Asynchronous reset while ch3 is held: outputs drop before any clock edge.
    #2 n_reset = 1'b0;
    #1;
    check("async_rst_level", {28'd0, bus.btn_level}, 32'd0);
    check("async_rst_pulses", {20'd0, bus.btn_press, bus.btn_release, bus.btn_long}, 32'd0);
    repeat (3) @(negedge clock);
    n_reset = 1'b1;

    // First tick lands SAMPLE_CNT clocks after reset release.
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.tick && n < 3000);
    check("first_tick_delay", n, 1000);

    // Next tick is one full period later; two samples are not yet enough.
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.tick && n < 3000);
    check("tick_period", n, 1001);
    @(negedge clock);
    check("rst_requal_wait", {28'd0, bus.btn_level}, 32'd0);

    push_ev("rst_requal", 4'b1000, 4'b0000, 4'b0000);
    wait_ticks(1);
    @(negedge clock);
    check("rst_requal_level", {28'd0, bus.btn_level}, 32'h8);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", ev_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_btn_debounce_multi

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised N-channel push-button conditioner and successor to the single-channel debouncer. It synchronises each raw button input and debounces it on a shared sample tick using a consecutive-sample stability filter. Per channel it provides a clean level, one-clock press and release pulses, and an optional long-press pulse. It sits between board button pins and control logic such as the SPI controller start/mode inputs.

## Interface
- N_BTN, 4: number of button channels (1..16).
- SAMPLE_CNT, 20'd1000: tick divider terminal count; tick period is SAMPLE_CNT+1 clocks. Use 1000 for simulation and 1000000 for 10 ms at 100 MHz. Must be ≥1.
- STABLE_SAMPLES, 3: consecutive differing samples required to flip a level (1..15).
- LONG_SAMPLES, 100: ticks a pressed level must persist to raise btn_long (2..65535).
- ACTIVE_LOW, 0: when 1, each raw input is inverted after synchronisation, so 0 on the pin means pressed.

- clock  input  1  system clock, all logic on its rising edge
- n_reset  input  1  asynchronous active-low reset
- btn_in  input  N_BTN  raw asynchronous button pins
- btn_level  output  N_BTN  debounced pressed level (1 = pressed)
- btn_press  output  N_BTN  one-clock pulse on debounced 0→1
- btn_release  output  N_BTN  one-clock pulse on debounced 1→0
- btn_long  output  N_BTN  one-clock pulse on long press
- tick  output  1  sample strobe, high one clock per period (for debug and sharing)

## Operation
- Reset (n_reset low, asynchronous) clears the tick counter, synchronisers, filter counters, hold counters and all outputs to 0.
- Tick counter: 20-bit, counts 0..SAMPLE_CNT and wraps to 0. tick is a combinational decode of cnt == SAMPLE_CNT.
- Synchroniser: a 2-FF chain per channel, then optional inversion (ACTIVE_LOW) giving s[i].
- Filter, per channel, evaluated only in tick cycles:
  - If s[i] == btn_level[i], the filter counter clears.
  - Otherwise the filter counter increments. When the increment would reach STABLE_SAMPLES, btn_level[i] toggles and the counter clears.
  - The counter is $clog2(STABLE_SAMPLES+1) bits wide and never exceeds STABLE_SAMPLES-1.
  - A single agreeing sample restarts the count, so glitches shorter than STABLE_SAMPLES ticks are rejected.
- Pulses:
  - btn_press[i] is high for exactly one clock on the edge where btn_level[i] goes 0→1.
  - btn_release[i] is high for exactly one clock on the edge where btn_level[i] goes 1→0.
  - Press and release never occur together on one channel.
- Long press (only when the configuration feature is compiled in):
  - A 16-bit hold counter per channel clears while btn_level[i] = 0 and on the flip to 1.
  - While btn_level[i] = 1, the hold counter increments once per tick and saturates at LONG_SAMPLES.
  - btn_long[i] pulses one clock on the tick where the counter reaches LONG_SAMPLES.
  - There is no repeat until the channel has been released and pressed again.
- Channels are fully independent. Any combination may flip or pulse in the same tick.

## Timing
- Input latency: 2 clocks for synchronisation, plus a wait for the next tick, plus (STABLE_SAMPLES-1) further ticks.
- btn_level and btn_press/btn_release update on the clock edge that ends the deciding tick cycle.
- Worst case, edge to pulse: 2 + STABLE_SAMPLES·(SAMPLE_CNT+1) clocks.
- btn_long rises exactly LONG_SAMPLES ticks after the tick that set btn_level.
- Release before LONG_SAMPLES ticks: no btn_long, and the hold counter clears.
- Reset mid-operation: all outputs go to 0 immediately, with no release pulse. After reset deasserts, a held button re-qualifies as a fresh press.

## Configuration
- BTN_LONG_PRESS_EN defined: hold counters and btn_long logic are built.
- BTN_LONG_PRESS_EN undefined: no hold counters. btn_long is tied to all zeros, LONG_SAMPLES is ignored, and all other behaviour is unchanged.

## Test plan
All scenarios use N_BTN=4, SAMPLE_CNT=1000, STABLE_SAMPLES=3, LONG_SAMPLES=5, ACTIVE_LOW=0.
- Clean press: btn_in[0] 0→1 and held → btn_level[0]=1, with a single btn_press[0] pulse within 3005 clocks. Other channels stay 0.
- Bounce rejection: btn_in[1] high for 2 ticks, low for 1, then high → no flip until 3 consecutive high ticks. Exactly one btn_press[1] in total.
- Release: btn_in[0] held 1 then dropped to 0 → one btn_release[0] pulse and btn_level[0]=0, with no btn_press.
- Long press, BTN_LONG_PRESS_EN defined: hold btn_in[2] → btn_long[2] exactly 5 ticks after btn_press[2], once only. With the macro undefined, btn_long stays 0.
- Simultaneous: btn_in = 4'b1111 in one clock → all four btn_press bits pulse in the same cycle.
- Reset mid-hold: assert n_reset while btn_level[3]=1 → all outputs 0 asynchronously. After deassert with the button still held, a fresh btn_press[3] arrives after 3 ticks.
